// File: rtl/dac_sample_out_if.sv
// Sample handshake between the voice-processing chain and the DAC output driver.
interface dac_sample_out_if;
    logic [11:0] wave_in;
    logic        wave_valid;
    logic        wave_ready;

    modport master (output wave_in, output wave_valid, input wave_ready);
    modport slave  (input wave_in, input wave_valid, output wave_ready);
endinterface

// File: rtl/dac_sample_out.sv
// DAC playback driver: offset removal with saturation, sample FIFO, fixed-rate
// output on a (optionally bit-reversed) parallel DAC bus with a generated DAC clock.
module dac_sample_out #(
    parameter int CH_offset  = 27,
    parameter int RATE_DIV   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit BIT_REV    = 1'b1
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    dac_sample_out_if.slave               wave_if,
    input  logic                          clr_status,
    output logic                          DA_clk,
    output logic [11:0]                   DA_data,
    output logic                          underflow,
    output logic                          underflow_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RATE_DIV);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(RATE_DIV - 1);
    localparam logic [CW-1:0]        CNT_HALF  = CW'(RATE_DIV / 2);
    localparam logic [AW:0]          LVL_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic signed [13:0]   OFFSET    = 14'(CH_offset);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           da_clk_q;
    logic [11:0]    out_q;
    logic           flag_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q, level_d;
    logic [11:0]    mem_q [FIFO_DEPTH];

    logic           tick, full, empty, push, pop;
    logic signed [13:0] diff;
    logic [11:0]    wr_data;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = wave_if.wave_valid && !full;
    // An empty FIFO is never popped, so a same-cycle write cannot bypass to the bus.
    assign pop   = tick && !empty;

    assign wave_if.wave_ready = !full;
    assign underflow          = tick && empty;
    assign underflow_flag     = flag_q;
    assign DA_clk             = da_clk_q;
    assign fifo_level         = level_q;

    // Remove the capture offset and clamp to the 12-bit DAC range.
    always_comb begin
        diff = $signed({2'b00, wave_if.wave_in}) - OFFSET;
        if (diff[13]) begin
            wr_data = 12'h000;
        end else if (diff > 14'sd4095) begin
            wr_data = 12'hFFF;
        end else begin
            wr_data = diff[11:0];
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            da_clk_q <= 1'b0;
            out_q    <= 12'h800;
            flag_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            // High for the second half of the period so the DAC latches stable data.
            da_clk_q <= (cnt_d >= CNT_HALF);
            level_q  <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                out_q    <= mem_q[rd_ptr_q];
            end
            if (underflow) begin
                flag_q <= 1'b1;
            end else if (clr_status) begin
                flag_q <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_bus
            if (BIT_REV) begin : g_rev
                assign DA_data[11 - gi] = out_q[gi];
            end else begin : g_straight
                assign DA_data[gi] = out_q[gi];
            end
        end
    endgenerate
endmodule
